keypad_matrix_emulator: RTL

- Models the physical 4x4 key matrix seen by a row-scanning keypad decoder, for FPGA loopback test without a real keypad.
- The decoder drives active-low one-hot row strobes `hl`. This block returns active-low column lines `vl` for one requested key, using real matrix (wired-AND) behaviour.
- Each key request is accepted through a valid/ready handshake. The block presses the key for a set number of row visits, releases it for a set number of row visits, then signals done.
- An optional contact-bounce phase and a no-scan timeout are included.

---
 rtl/keypad_matrix_emulator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_emulator.sv
// Emulates a 4x4 passive key matrix for loopback testing of a row-scanning keypad decoder.
// One key is pressed per accepted request: optional bounce, HOLD visits, RELEASE visits, then done.
module keypad_matrix_emulator #(
    parameter int HOLD_SCANS     = 4,
    parameter int RELEASE_SCANS  = 2,
    parameter int BOUNCE_CYCLES  = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] hl,
    output logic [3:0] vl,
    output logic       pressed,
    output logic       done,
    output logic       timeout,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BOUNCE  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int HW = $clog2(HOLD_SCANS) + 1;
    localparam int RW = $clog2(RELEASE_SCANS) + 1;
    localparam int BW = $clog2(BOUNCE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SCANS - 1);
    localparam logic [RW-1:0] REL_LAST  = RW'(RELEASE_SCANS - 1);
    localparam logic [BW-1:0] BNC_LAST  = BW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [3:0]    key_q, key_d;
    logic [3:0]    hl_prev_q;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rel_cnt_q, rel_cnt_d;
    logic [BW-1:0] bnc_cnt_q, bnc_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    lfsr_q, lfsr_d;

    logic [1:0] row;
    logic [1:0] col;
    logic       visit;
    logic       to_hit;
    logic       active;

    assign row    = key_q[3:2];
    assign col    = key_q[1:0];
    // A visit is the falling edge of the latched key's row strobe.
    assign visit  = ~hl[row] & hl_prev_q[row];
    assign to_hit = (to_cnt_q == TO_LAST);

    // x^8 + x^6 + x^5 + x^4 + 1, free-running in every state.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= 4'h0;
            hl_prev_q  <= 4'hF;
            hold_cnt_q <= '0;
            rel_cnt_q  <= '0;
            bnc_cnt_q  <= '0;
            to_cnt_q   <= '0;
            lfsr_q     <= 8'hA5;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            hl_prev_q  <= hl;
            hold_cnt_q <= hold_cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            bnc_cnt_q  <= bnc_cnt_d;
            to_cnt_q   <= to_cnt_d;
            lfsr_q     <= lfsr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        hold_cnt_d = hold_cnt_q;
        rel_cnt_d  = rel_cnt_q;
        bnc_cnt_d  = bnc_cnt_q;
        to_cnt_d   = to_cnt_q;
        active     = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (key_valid) begin
                    key_d      = key_code;
                    hold_cnt_d = '0;
                    rel_cnt_d  = '0;
                    bnc_cnt_d  = '0;
                    state_d    = (BOUNCE_CYCLES > 0) ? BOUNCE : HOLD;
                end
            end
            BOUNCE: begin
                active   = lfsr_q[0];
                to_cnt_d = '0;
                if (bnc_cnt_q == BNC_LAST) begin
                    state_d = HOLD;
                end else begin
                    bnc_cnt_d = bnc_cnt_q + BW'(1);
                end
            end
            HOLD: begin
                active = 1'b1;
                // A visit on the terminal-count cycle wins over the timeout.
                if (visit) begin
                    to_cnt_d = '0;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = RELEASE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end else if (to_hit) begin
                    active  = 1'b0;
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            RELEASE: begin
                if (visit) begin
                    to_cnt_d = '0;
                    if (rel_cnt_q == REL_LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rel_cnt_d = rel_cnt_q + RW'(1);
                    end
                end else if (to_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            to_cnt_d = '0;
        end
    end

    // Wired-AND matrix: only the pressed key's column can be pulled low.
    always_comb begin
        vl = 4'hF;
        for (int c = 0; c < 4; c++) begin
            vl[c] = ~(active & (col == 2'(c)) & ~hl[row]);
        end
    end

    assign key_ready = (state_q == IDLE);
    assign pressed   = active;
    assign dbg_state = state_q;

endmodule
